// File: rtl/alu_reg_datapath_pkg.sv
// Shared constants for the ALU/register datapath: opcodes, default sizes, address width.
// Optional opcodes 4-7 are enabled by ALU_EXT_OPS_EN in alu_core.
package alu_reg_pkg;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_NREGS    = 4;
    localparam int DEF_PC_WIDTH = 8;
    localparam int DEF_AW       = (DEF_NREGS > 1) ? $clog2(DEF_NREGS) : 1;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_SHL  = 3'd5;
    localparam logic [2:0] OP_SHR  = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;
endpackage

// File: rtl/alu_reg_datapath_if.sv
// Controller-to-datapath strobe/address bundle plus loader port and datapath results.
// master = controller/loader side, slave = datapath side.
interface alu_reg_datapath_if
    import alu_reg_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NREGS    = DEF_NREGS,
    parameter int PC_WIDTH = DEF_PC_WIDTH
);
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic                reg1_out, alu_a, reg2_out, alu_b, reg_dest;
    logic                pc_inc, done, alu_in_en, alu_out_en;
    logic [AW-1:0]       src1, src2, dest;
    logic [2:0]          opcode;
    logic                cfg_we;
    logic [AW-1:0]       cfg_addr;
    logic [WIDTH-1:0]    cfg_data;
    logic [WIDTH-1:0]    result_out;
    logic                zero_flag, carry_flag, result_valid;
    logic [PC_WIDTH-1:0] pc;
    logic                proto_err;

    modport master (
        output reg1_out, alu_a, reg2_out, alu_b, reg_dest, pc_inc, done, alu_in_en, alu_out_en,
        output src1, src2, dest, opcode, cfg_we, cfg_addr, cfg_data,
        input  result_out, zero_flag, carry_flag, result_valid, pc, proto_err
    );

    modport slave (
        input  reg1_out, alu_a, reg2_out, alu_b, reg_dest, pc_inc, done, alu_in_en, alu_out_en,
        input  src1, src2, dest, opcode, cfg_we, cfg_addr, cfg_data,
        output result_out, zero_flag, carry_flag, result_valid, pc, proto_err
    );
endinterface

// File: rtl/alu_reg_datapath_alu_core.sv
// Combinational ALU: WIDTH+1 result with carry/borrow in the top bit; zero latency, no backpressure.
// Opcodes 4-7 exist only with ALU_EXT_OPS_EN; otherwise they return 0 and raise illegal.
module alu_core
    import alu_reg_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       opcode,
    output logic [WIDTH:0]   res,
    output logic             illegal
);
    always_comb begin
        res     = '0;
        illegal = 1'b0;
        case (opcode)
            OP_ADD:  res = {1'b0, a} + {1'b0, b};
            OP_SUB:  res = {1'b0, a} - {1'b0, b};
            OP_AND:  res = {1'b0, a & b};
            OP_OR:   res = {1'b0, a | b};
`ifdef ALU_EXT_OPS_EN
            OP_XOR:  res = {1'b0, a ^ b};
            OP_SHL:  res = {a, 1'b0};
            OP_SHR:  res = {a[0], 1'b0, a[WIDTH-1:1]};
            OP_PASS: res = {1'b0, a};
            default: res = '0;
`else
            default: illegal = 1'b1;
`endif
        endcase
    end
endmodule

// File: rtl/alu_reg_datapath.sv
// Strobe-driven register/ALU datapath; each strobe acts on the next clk edge, no backpressure.
// Register file, operand latches, PC and done/pc_inc edge detect; ALU_EXT_OPS_EN adds opcodes 4-7.
module alu_reg_datapath
    import alu_reg_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NREGS    = DEF_NREGS,
    parameter int PC_WIDTH = DEF_PC_WIDTH
) (
    input  logic clk,
    input  logic reset,
    alu_reg_datapath_if.slave bus
);
    logic [WIDTH-1:0]    regs [NREGS];
    logic [WIDTH-1:0]    a_q, b_q, rd1, rd2;
    logic [WIDTH:0]      res_q, alu_res;
    logic                alu_illegal;
    logic [PC_WIDTH-1:0] pc_q;
    logic                pc_inc_q, done_q;
    logic [WIDTH-1:0]    result_q;
    logic                zero_q, carry_q, valid_q, err_q;

    logic any_strobe, lat_a, lat_b, wb_en, cfg_en, err_now;

    assign rd1 = regs[bus.src1];
    assign rd2 = regs[bus.src2];

    assign any_strobe = bus.reg1_out | bus.alu_a | bus.reg2_out | bus.alu_b | bus.reg_dest |
                        bus.pc_inc | bus.done | bus.alu_in_en | bus.alu_out_en;

    assign lat_a  = bus.reg1_out & bus.alu_a & ~bus.reg2_out;
    assign lat_b  = bus.reg2_out & bus.alu_b & ~bus.reg1_out;
    assign wb_en  = bus.alu_out_en & bus.reg_dest;
    assign cfg_en = bus.cfg_we & ~any_strobe;

    assign err_now = (bus.reg1_out & bus.reg2_out) |
                     (bus.alu_a & ~bus.reg1_out) |
                     (bus.alu_b & ~bus.reg2_out) |
                     (bus.reg_dest & ~bus.alu_out_en) |
                     (bus.cfg_we & any_strobe) |
                     (bus.alu_in_en & alu_illegal);

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .a       (a_q),
        .b       (b_q),
        .opcode  (bus.opcode),
        .res     (alu_res),
        .illegal (alu_illegal)
    );

    // Reads are combinational from the pre-edge array, so a same-cycle write-back is not bypassed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wb_en) begin
            regs[bus.dest] <= res_q[WIDTH-1:0];
        end else if (cfg_en) begin
            regs[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            pc_q     <= '0;
            pc_inc_q <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (lat_a)         a_q   <= rd1;
            if (lat_b)         b_q   <= rd2;
            if (bus.alu_in_en) res_q <= alu_res;
            pc_inc_q <= bus.pc_inc;
            done_q   <= bus.done;
            if (bus.pc_inc && !pc_inc_q) pc_q <= pc_q + 1'b1;
            valid_q  <= bus.done & ~done_q;
            if (bus.done && !done_q) begin
                result_q <= res_q[WIDTH-1:0];
                zero_q   <= (res_q[WIDTH-1:0] == '0);
                carry_q  <= res_q[WIDTH];
            end
            err_q <= err_q | err_now;
        end
    end

    assign bus.result_out   = result_q;
    assign bus.zero_flag    = zero_q;
    assign bus.carry_flag   = carry_q;
    assign bus.result_valid = valid_q;
    assign bus.pc           = pc_q;
    assign bus.proto_err    = err_q;
endmodule

// File: tb/tb_alu_reg_datapath.sv
// Directed table-driven bench for alu_reg_datapath plus hand sequences for PC, reset and errors.
module tb_alu_reg_datapath;
    logic clk;
    logic reset;
    int   tests;
    int   fails;
    logic [7:0] exp_pc;

    alu_reg_datapath_if bus ();

    alu_reg_datapath dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [1:0] dest;
        logic [7:0] res;
        logic       z;
        logic       c;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes;
        bus.reg1_out = 0; bus.alu_a = 0; bus.reg2_out = 0; bus.alu_b = 0;
        bus.reg_dest = 0; bus.pc_inc = 0; bus.done = 0;
        bus.alu_in_en = 0; bus.alu_out_en = 0; bus.cfg_we = 0;
    endtask

    task automatic load(input logic [1:0] addr, input logic [7:0] data);
        bus.cfg_we = 1; bus.cfg_addr = addr; bus.cfg_data = data;
        tick;
        bus.cfg_we = 0;
    endtask

    task automatic run_seq(input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] d,
                           input logic [2:0] op, output logic rv_first, output logic rv_next);
        bus.src1 = s1; bus.src2 = s2; bus.dest = d; bus.opcode = op;
        bus.reg1_out = 1; bus.alu_a = 1; tick; clear_strobes;
        bus.reg2_out = 1; bus.alu_b = 1; tick; clear_strobes;
        bus.alu_in_en = 1; tick; clear_strobes;
        bus.alu_out_en = 1; bus.reg_dest = 1; bus.pc_inc = 1; tick; clear_strobes;
        bus.done = 1; tick;
        rv_first = bus.result_valid;
        bus.done = 0; tick;
        rv_next = bus.result_valid;
    endtask

    task automatic pulse_reset;
        #1 reset = 0;
        tick;
        reset = 1;
        tick;
    endtask

    initial begin
        logic rv1, rv2;
        tests = 0; fails = 0; exp_pc = 0;
        vecs[0] = '{a: 8'h05, b: 8'h03, op: 3'd0, dest: 2'd2, res: 8'h08, z: 1'b0, c: 1'b0};
        vecs[1] = '{a: 8'h03, b: 8'h05, op: 3'd1, dest: 2'd3, res: 8'hFE, z: 1'b0, c: 1'b1};
        vecs[2] = '{a: 8'h80, b: 8'h80, op: 3'd0, dest: 2'd2, res: 8'h00, z: 1'b1, c: 1'b1};
        vecs[3] = '{a: 8'hF0, b: 8'h3C, op: 3'd2, dest: 2'd3, res: 8'h30, z: 1'b0, c: 1'b0};
        vecs[4] = '{a: 8'hF0, b: 8'h0F, op: 3'd3, dest: 2'd2, res: 8'hFF, z: 1'b0, c: 1'b0};
        vecs[5] = '{a: 8'h07, b: 8'h07, op: 3'd1, dest: 2'd3, res: 8'h00, z: 1'b1, c: 1'b0};
        vecs[6] = '{a: 8'hFF, b: 8'h01, op: 3'd0, dest: 2'd2, res: 8'h00, z: 1'b1, c: 1'b1};
        vecs[7] = '{a: 8'h0A, b: 8'h05, op: 3'd2, dest: 2'd3, res: 8'h00, z: 1'b1, c: 1'b0};

        reset = 0;
        clear_strobes;
        bus.src1 = 0; bus.src2 = 0; bus.dest = 0; bus.opcode = 0;
        bus.cfg_addr = 0; bus.cfg_data = 0;
        tick; tick;
        chk("rst_pc", bus.pc, 0);
        chk("rst_result", bus.result_out, 0);
        chk("rst_valid", bus.result_valid, 0);
        chk("rst_err", bus.proto_err, 0);
        chk("rst_flags", {bus.zero_flag, bus.carry_flag}, 0);
        reset = 1;
        tick;

        for (int i = 0; i < 8; i++) begin
            load(2'd0, vecs[i].a);
            load(2'd1, vecs[i].b);
            run_seq(2'd0, 2'd1, vecs[i].dest, vecs[i].op, rv1, rv2);
            exp_pc = exp_pc + 1;
            chk($sformatf("v%0d_result", i), bus.result_out, vecs[i].res);
            chk($sformatf("v%0d_zero", i), bus.zero_flag, vecs[i].z);
            chk($sformatf("v%0d_carry", i), bus.carry_flag, vecs[i].c);
            chk($sformatf("v%0d_wb", i), dut.regs[vecs[i].dest], vecs[i].res);
            chk($sformatf("v%0d_valid_pulse", i), {rv1, rv2}, 2'b10);
            chk($sformatf("v%0d_pc", i), bus.pc, exp_pc);
            chk($sformatf("v%0d_err", i), bus.proto_err, 0);
        end

        // pc_inc held for three cycles counts once
        bus.pc_inc = 1; tick; tick; tick; bus.pc_inc = 0; tick;
        exp_pc = exp_pc + 1;
        chk("pc_hold", bus.pc, exp_pc);

        while (exp_pc != 8'hFF) begin
            bus.pc_inc = 1; tick; bus.pc_inc = 0; tick;
            exp_pc = exp_pc + 1;
        end
        chk("pc_at_ff", bus.pc, 8'hFF);
        load(2'd0, 8'h01);
        load(2'd1, 8'h02);
        run_seq(2'd0, 2'd1, 2'd2, 3'd0, rv1, rv2);
        chk("pc_wrap", bus.pc, 8'h00);
        chk("wrap_result", bus.result_out, 8'h03);

        // write-back and read of the same register in one cycle: read sees old value
        load(2'd0, 8'h05);
        load(2'd1, 8'h03);
        run_seq(2'd0, 2'd1, 2'd2, 3'd0, rv1, rv2);
        bus.src1 = 0; bus.dest = 0;
        bus.reg1_out = 1; bus.alu_a = 1; bus.alu_out_en = 1; bus.reg_dest = 1;
        tick; clear_strobes;
        chk("coll_a_old", dut.a_q, 8'h05);
        chk("coll_wb", dut.regs[0], 8'h08);
        chk("coll_err", bus.proto_err, 0);

        // bus conflict: nothing latched, sticky error
        bus.src1 = 0; bus.src2 = 2;
        bus.reg1_out = 1; bus.reg2_out = 1; bus.alu_a = 1; bus.alu_b = 1;
        tick; clear_strobes;
        chk("conf_a", dut.a_q, 8'h05);
        chk("conf_b", dut.b_q, 8'h03);
        chk("conf_err", bus.proto_err, 1);
        tick; tick; tick;
        chk("conf_err_sticky", bus.proto_err, 1);

        // asynchronous reset after A is latched
        load(2'd0, 8'h22);
        load(2'd1, 8'h11);
        bus.src1 = 0; bus.reg1_out = 1; bus.alu_a = 1; tick; clear_strobes;
        chk("mid_a_latched", dut.a_q, 8'h22);
        #1 reset = 0;
        #1;
        chk("async_pc", bus.pc, 0);
        chk("async_result", bus.result_out, 0);
        chk("async_err", bus.proto_err, 0);
        chk("async_a", dut.a_q, 0);
        chk("async_reg0", dut.regs[0], 0);
        tick;
        reset = 1;
        tick;
        load(2'd0, 8'h22);
        load(2'd1, 8'h11);
        run_seq(2'd0, 2'd1, 2'd3, 3'd1, rv1, rv2);
        chk("fresh_result", bus.result_out, 8'h11);
        chk("fresh_flags", {bus.zero_flag, bus.carry_flag}, 2'b00);
        chk("fresh_wb", dut.regs[3], 8'h11);
        chk("fresh_pc", bus.pc, 1);

        // loader write while a strobe is active is dropped
        load(2'd0, 8'h44);
        bus.cfg_we = 1; bus.cfg_addr = 0; bus.cfg_data = 8'h99; bus.alu_in_en = 1;
        tick; clear_strobes;
        chk("cfg_blocked", dut.regs[0], 8'h44);
        chk("cfg_err", bus.proto_err, 1);
        pulse_reset;

        // opcode 4
        load(2'd0, 8'hF0);
        load(2'd1, 8'hFF);
        run_seq(2'd0, 2'd1, 2'd2, 3'd4, rv1, rv2);
`ifdef ALU_EXT_OPS_EN
        chk("op4_result", bus.result_out, 8'h0F);
        chk("op4_err", bus.proto_err, 0);
`else
        chk("op4_result", bus.result_out, 8'h00);
        chk("op4_err", bus.proto_err, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
